sequencer: RTL

SEQUENCER -- requirements
Module: sequencer

---
 rtl/sequencer_pkg.sv | 31 +++
 rtl/sequencer.sv | 88 ++++++++
 2 files changed

// File: rtl/sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encodings, decoder
// cycle constants, the NOP encoding and the default fetch/trap vectors.
package sequencer_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned CYC_W      = 3;
  localparam int unsigned INSTRET_W  = 32;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } seq_state_e;

  // Decoder cycle number at which an instruction completes
  localparam logic [CYC_W-1:0] DECODE_TERMINAL = 3'd3;

  // ADDI x0,x0,0
  localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 64'h0000_0000_0000_0100;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 64'h0000_0000_0000_0200;

  // Sequential next PC; wraps modulo 2^64 and never touches bits [1:0]
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    pc_step = pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/sequencer.sv
// Instruction sequencer: fetches one word at PC, then steps the decoder
// through its cycles until the terminal cycle retires the instruction or an
// undefined encoding diverts to the trap vector.
module sequencer
  import sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [63:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        istb_o,
  output logic [63:0] iadr_o,
  input  logic        iack_i,
  input  logic [31:0] idat_i,
  output logic [31:0] ir_o,
  output logic [2:0]  state_o,
  input  logic [2:0]  nstate_i,
  input  logic        defined_i,
  output logic        trap_o,
  output logic [63:0] epc_o,
  output logic [31:0] instret_o
);

  seq_state_e           fsm_q;
  logic [XLEN-1:0]      pc_q;
  logic [ILEN-1:0]      ir_q;
  logic [CYC_W-1:0]     cyc_q;
  logic [XLEN-1:0]      epc_q;
  logic [INSTRET_W-1:0] instret_q;

  // Sequencer FSM with PC, IR, cycle, EPC and retire-count registers
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fsm_q     <= ST_FETCH;
      pc_q      <= RESET_VECTOR;
      ir_q      <= NOP_INSN;
      cyc_q     <= '0;
      epc_q     <= '0;
      instret_q <= '0;
    end else begin
      unique case (fsm_q)
        ST_FETCH: begin
          // Wait as long as it takes for the acknowledge
          if (iack_i) begin
            ir_q  <= idat_i;
            cyc_q <= '0;
            fsm_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Undefined encoding wins over retire and cycle advance
          if (!defined_i) begin
            fsm_q <= ST_TRAP;
          end else if (cyc_q == DECODE_TERMINAL) begin
            pc_q      <= pc_step(pc_q);
            instret_q <= instret_q + INSTRET_W'(1);
            cyc_q     <= '0;
            fsm_q     <= ST_FETCH;
          end else begin
            // nstate_i equal to the current cycle is a legal stall
            cyc_q <= nstate_i;
          end
        end
        ST_TRAP: begin
          epc_q <= pc_q;
          pc_q  <= TRAP_VECTOR;
          cyc_q <= '0;
          fsm_q <= ST_FETCH;
        end
        default: begin
          fsm_q <= ST_FETCH;
        end
      endcase
    end
  end

  // Fetch strobe and trap pulse follow the FSM, held low while in reset
  assign istb_o = reset_i && (fsm_q == ST_FETCH);
  assign trap_o = reset_i && (fsm_q == ST_TRAP);

  assign iadr_o    = pc_q;
  assign ir_o      = ir_q;
  assign state_o   = cyc_q;
  assign epc_o     = epc_q;
  assign instret_o = instret_q;

endmodule
